// File: rtl/sha1_compress_iter_if.sv
// Block/digest handshake bundle for sha1_compress_iter.
// Optional first_i exists only when SHA1_CHAIN_EN is defined.
`timescale 1ns/1ps
interface sha1_compress_iter_if;
    // Both sides use valid/ready: a transfer happens on a rising clk edge
    // where valid and ready are both high; the source holds data until then.
    logic         in_valid_i;
    logic         in_ready_o;
    logic [511:0] block_i;
    logic [159:0] h_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [159:0] digest_o;
`ifdef SHA1_CHAIN_EN
    logic         first_i;

    modport slave (
        input  in_valid_i, block_i, h_i, first_i, out_ready_i,
        output in_ready_o, out_valid_o, digest_o
    );
    modport master (
        output in_valid_i, block_i, h_i, first_i, out_ready_i,
        input  in_ready_o, out_valid_o, digest_o
    );
`else
    modport slave (
        input  in_valid_i, block_i, h_i, out_ready_i,
        output in_ready_o, out_valid_o, digest_o
    );
    modport master (
        output in_valid_i, block_i, h_i, out_ready_i,
        input  in_ready_o, out_valid_o, digest_o
    );
`endif
endinterface

// File: rtl/sha1_compress_iter.sv
// Iterative SHA-1 compression, ROUNDS rounds per clock, IDLE/RUN/DONE FSM.
// Optional macro SHA1_CHAIN_EN: H comes from the IV or the previous digest.
`timescale 1ns/1ps
module sha1_compress_iter #(
    parameter int ROUNDS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    sha1_compress_iter_if.slave  bus,
    output logic [1:0]           dbg_state_o
);

    generate
        if (!(ROUNDS == 1 || ROUNDS == 2 || ROUNDS == 4 ||
              ROUNDS == 5 || ROUNDS == 10 || ROUNDS == 20)) begin : g_bad_rounds
            $error("sha1_compress_iter: ROUNDS must be 1, 2, 4, 5, 10 or 20");
        end
    endgenerate

    localparam logic [6:0] STEP = 7'(ROUNDS);
    localparam logic [6:0] LAST = 7'(80 - ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic [6:0]   cnt_q, cnt_d;
    logic [31:0]  work_q [5];
    logic [31:0]  work_d [5];
    logic [31:0]  h_q [5];
    logic [31:0]  h_d [5];
    logic [31:0]  w_q [16];
    logic [31:0]  w_d [16];
    logic [159:0] digest_q, digest_d;
    logic         out_valid_q, out_valid_d;

    logic [159:0] h_sel;
    logic [31:0]  rnd [5];
    logic [31:0]  win [16];
    logic [31:0]  f, k, tmp, nw;
    logic [6:0]   t;
    logic [159:0] sum;

    function automatic logic [31:0] rotl1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction
    function automatic logic [31:0] rotl5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction
    function automatic logic [31:0] rotl30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

`ifdef SHA1_CHAIN_EN
    localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    logic [159:0] chain_q, chain_d;
    assign h_sel = bus.first_i ? IV : chain_q;
`else
    assign h_sel = bus.h_i;
`endif

    always_comb begin
        rnd = work_q;
        win = w_q;
        f   = '0;
        k   = '0;
        tmp = '0;
        nw  = '0;
        t   = '0;
        // win[0] is always W[t]; the schedule is extended one word per round
        for (int r = 0; r < ROUNDS; r++) begin
            t = cnt_q + 7'(r);
            if (t < 7'd20) begin
                f = (rnd[1] & rnd[2]) | (~rnd[1] & rnd[3]);
                k = 32'h5a827999;
            end else if (t < 7'd40) begin
                f = rnd[1] ^ rnd[2] ^ rnd[3];
                k = 32'h6ed9eba1;
            end else if (t < 7'd60) begin
                f = (rnd[1] & rnd[2]) | (rnd[1] & rnd[3]) | (rnd[2] & rnd[3]);
                k = 32'h8f1bbcdc;
            end else begin
                f = rnd[1] ^ rnd[2] ^ rnd[3];
                k = 32'hca62c1d6;
            end
            tmp    = rotl5(rnd[0]) + f + rnd[4] + k + win[0];
            rnd[4] = rnd[3];
            rnd[3] = rnd[2];
            rnd[2] = rotl30(rnd[1]);
            rnd[1] = rnd[0];
            rnd[0] = tmp;
            nw = rotl1(win[13] ^ win[8] ^ win[2] ^ win[0]);
            for (int j = 0; j < 15; j++) begin
                win[j] = win[j + 1];
            end
            win[15] = nw;
        end

        sum = '0;
        for (int i = 0; i < 5; i++) begin
            sum[159 - 32*i -: 32] = h_q[i] + rnd[i];
        end

        state_d     = state_q;
        cnt_d       = cnt_q;
        work_d      = work_q;
        h_d         = h_q;
        w_d         = w_q;
        digest_d    = digest_q;
        out_valid_d = out_valid_q;
`ifdef SHA1_CHAIN_EN
        chain_d     = chain_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.in_valid_i) begin
                    for (int i = 0; i < 16; i++) begin
                        w_d[i] = bus.block_i[511 - 32*i -: 32];
                    end
                    for (int i = 0; i < 5; i++) begin
                        h_d[i]    = h_sel[159 - 32*i -: 32];
                        work_d[i] = h_sel[159 - 32*i -: 32];
                    end
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                work_d = rnd;
                w_d    = win;
                cnt_d  = cnt_q + STEP;
                if (cnt_q == LAST) begin
                    digest_d    = sum;
                    out_valid_d = 1'b1;
                    state_d     = S_DONE;
`ifdef SHA1_CHAIN_EN
                    chain_d     = sum;
`endif
                end
            end
            S_DONE: begin
                if (bus.out_ready_i) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            work_q      <= '{default: '0};
            h_q         <= '{default: '0};
            w_q         <= '{default: '0};
            digest_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef SHA1_CHAIN_EN
            chain_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            h_q         <= h_d;
            w_q         <= w_d;
            digest_q    <= digest_d;
            out_valid_q <= out_valid_d;
`ifdef SHA1_CHAIN_EN
            chain_q     <= chain_d;
`endif
        end
    end

    assign bus.in_ready_o  = (state_q == S_IDLE);
    assign bus.out_valid_o = out_valid_q;
    assign bus.digest_o    = digest_q;
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_sha1_compress_iter.sv
// Scoreboard bench for sha1_compress_iter: known vectors, backpressure,
// mid-run reset, noisy input buses and random blocks against a reference model.
`timescale 1ns/1ps
module tb_sha1_compress_iter;

    localparam int ROUNDS = 5;
    localparam int LAT    = 80 / ROUNDS;

    localparam logic [159:0] IV      = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
    localparam logic [159:0] D_ABC   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
    localparam logic [159:0] D_TWO   = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;

    localparam logic [511:0] B_ABC   = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] B_EMPTY = {32'h80000000, 480'h0};
    localparam logic [511:0] B_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] B_TWO2  = {480'h0, 32'h000001c0};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         last_hs = 0;
    logic [159:0] exp_q[$];

    sha1_compress_iter_if bus_if ();

    sha1_compress_iter #(.ROUNDS(ROUNDS)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus_if),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Straight textbook SHA-1 compression with a full 80-word schedule.
    function automatic logic [159:0] sha1_ref(input logic [511:0] blk, input logic [159:0] h);
        logic [31:0] w [80];
        logic [31:0] a, b, c, d, e, f, k, tmp;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 80; i++) w[i] = rotl(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
        a = h[159:128]; b = h[127:96]; c = h[95:64]; d = h[63:32]; e = h[31:0];
        for (int i = 0; i < 80; i++) begin
            if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5a827999; end
            else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ed9eba1; end
            else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8f1bbcdc; end
            else             begin f = b ^ c ^ d;                   k = 32'hca62c1d6; end
            tmp = rotl(a, 5) + f + e + k + w[i];
            e = d; d = c; c = rotl(b, 30); b = a; a = tmp;
        end
        return {h[159:128] + a, h[127:96] + b, h[95:64] + c, h[63:32] + d, h[31:0] + e};
    endfunction

    task automatic run_job(input logic [511:0] blk, input logic [159:0] h, input logic [159:0] exp,
                           input int stall, input bit noisy, input bit chk_gap);
        int n;
        int lat;
        int acc;
        logic [159:0] got_exp;
        exp_q.push_back(exp);
        bus_if.block_i    = blk;
        bus_if.h_i        = h;
        bus_if.in_valid_i = 1'b1;
        n = 0;
        while (!bus_if.in_ready_o && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", 160'(n < 20), 160'(1));
        @(posedge clk); #1;
        acc = cyc;
        bus_if.in_valid_i = 1'b0;
        if (chk_gap) check("accept_gap", 160'(acc - last_hs), 160'(1));

        lat = 0;
        while (!bus_if.out_valid_o && lat < 200) begin
            if (noisy) begin
                bus_if.block_i    = {16{$urandom}};
                bus_if.h_i        = {5{$urandom}};
                bus_if.in_valid_i = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            lat++;
            if (noisy && !bus_if.out_valid_o) check("ready_run", 160'(bus_if.in_ready_o), 160'(0));
        end
        check("latency", 160'(lat), 160'(LAT));

        for (int s = 0; s < stall; s++) begin
            if (noisy) bus_if.in_valid_i = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check("stall_digest", bus_if.digest_o, exp_q[0]);
            check("stall_valid", 160'(bus_if.out_valid_o), 160'(1));
            check("stall_ready", 160'(bus_if.in_ready_o), 160'(0));
        end

        bus_if.in_valid_i  = 1'b0;
        bus_if.out_ready_i = 1'b1;
        got_exp = exp_q.pop_front();
        check("digest", bus_if.digest_o, got_exp);
        check("out_valid", 160'(bus_if.out_valid_o), 160'(1));
        @(posedge clk); #1;
        last_hs = cyc;
        bus_if.out_ready_i = 1'b0;
        check("post_hs_valid", 160'(bus_if.out_valid_o), 160'(0));
        check("post_hs_ready", 160'(bus_if.in_ready_o), 160'(1));
        check("post_hs_digest", bus_if.digest_o, got_exp);
    endtask

    initial begin
        logic [159:0] d1;
        logic [511:0] rb;
        logic [159:0] rh;
        bit           seen_valid;

        bus_if.in_valid_i  = 1'b0;
        bus_if.out_ready_i = 1'b0;
        bus_if.block_i     = '0;
        bus_if.h_i         = '0;
`ifdef SHA1_CHAIN_EN
        bus_if.first_i     = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ready", 160'(bus_if.in_ready_o), 160'(1));
        check("rst_valid", 160'(bus_if.out_valid_o), 160'(0));
        check("rst_digest", bus_if.digest_o, 160'(0));
        check("rst_state", 160'(dbg_state), 160'(0));

        run_job(B_ABC, IV, D_ABC, 0, 1'b0, 1'b0);
        run_job(B_EMPTY, IV, D_EMPTY, 3, 1'b0, 1'b1);

        d1 = sha1_ref(B_TWO1, IV);
        run_job(B_TWO1, IV, d1, 37, 1'b1, 1'b1);
`ifdef SHA1_CHAIN_EN
        bus_if.first_i = 1'b0;
`endif
        run_job(B_TWO2, d1, D_TWO, 0, 1'b0, 1'b1);
`ifdef SHA1_CHAIN_EN
        bus_if.first_i = 1'b1;
`endif
        run_job(B_ABC, IV, D_ABC, 2, 1'b1, 1'b1);

        // Abort a job at cnt = 40 with a single-cycle reset
        bus_if.block_i    = B_ABC;
        bus_if.h_i        = IV;
        bus_if.in_valid_i = 1'b1;
        @(posedge clk); #1;
        bus_if.in_valid_i = 1'b0;
        repeat (40 / ROUNDS) @(posedge clk);
        #1;
        check("abort_state_run", 160'(dbg_state), 160'(1));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ready", 160'(bus_if.in_ready_o), 160'(1));
        check("abort_valid", 160'(bus_if.out_valid_o), 160'(0));
        check("abort_digest", bus_if.digest_o, 160'(0));
        check("abort_state", 160'(dbg_state), 160'(0));
        seen_valid = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(posedge clk); #1;
            if (bus_if.out_valid_o) seen_valid = 1'b1;
        end
        check("abort_no_output", 160'(seen_valid), 160'(0));
        run_job(B_ABC, IV, D_ABC, 1, 1'b0, 1'b0);

        for (int j = 0; j < 3; j++) begin
            rb = {16{$urandom}};
            for (int i = 0; i < 16; i++) rb[511 - 32*i -: 32] = $urandom;
            rh = {$urandom, $urandom, $urandom, $urandom, $urandom};
`ifdef SHA1_CHAIN_EN
            rh = IV;
`endif
            run_job(rb, rh, sha1_ref(rb, rh), $urandom_range(0, 5), 1'b0, 1'b1);
        end

        check("queue_empty", 160'(exp_q.size()), 160'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
